// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular byte FIFO feeding a UART transmitter via tx_enable/tx_ready.
// Latency: 2 cycles from an accepted write into an empty queue (tx_ready=1) to tx_enable_o high.
// Backpressure: writes while full are dropped; sticky ovf_o only when UART_TXQ_OVF_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i,
  input  logic          tx_ready_i,
  output logic          tx_enable_o,
  output logic [7:0]    tx_parallel_o
);

  localparam logic [AW:0] DepthC = DEPTH[AW:0];

  // IDLE/GAP hold tx_enable low, ARM/BUSY hold it high for the whole frame.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    BUSY = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          tx_enable_q;
  logic [7:0]    tx_parallel_q, tx_parallel_d;
  logic          ovf_q, ovf_d;
  logic          wr_acc;
  logic          pop;

  assign wr_acc = wr_en_i & ~full_q;

  // Transmit sequencer: pop in IDLE, wait for the frame to start and finish, then force one low cycle.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    tx_parallel_d = tx_parallel_q;
    case (state_q)
      IDLE: begin
        if (!empty_q && tx_ready_i) begin
          pop           = 1'b1;
          tx_parallel_d = mem_q[rd_ptr_q];
          state_d       = ARM;
        end
      end
      ARM:     if (!tx_ready_i) state_d = BUSY;
      BUSY:    if (tx_ready_i)  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy bookkeeping; a simultaneous write and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef UART_TXQ_OVF_EN
  // Sticky overflow: a dropped write sets it and wins over a same-cycle clear.
  always_comb begin
    ovf_d = (wr_en_i & full_q) | (ovf_q & ~ovf_clr_i);
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr_i;

  // Overflow reporting compiled out; dropped writes stay silent.
  always_comb begin
    ovf_d = 1'b0;
  end
`endif

  // Storage array carries no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // All control state and registered outputs; reset drops tx_enable immediately mid-frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      tx_enable_q   <= 1'b0;
      tx_parallel_q <= 8'h00;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= (count_d == DepthC);
      empty_q       <= (count_d == '0);
      tx_enable_q   <= (state_d == ARM) || (state_d == BUSY);
      tx_parallel_q <= tx_parallel_d;
      ovf_q         <= ovf_d;
    end
  end

  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign count_o       = count_q;
  assign ovf_o         = ovf_q;
  assign tx_enable_o   = tx_enable_q;
  assign tx_parallel_o = tx_parallel_q;

endmodule
